// File: rtl/rf_multi_pkg.sv
// Shared defaults and helpers for the multi-port register file.
// Imported by rf_multi and rf_read_port.
package rf_multi_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_DEPTH  = 32;
    localparam int DEF_RPORTS = 2;

    // Address width for a given depth; a single-entry file still needs one bit.
    function automatic int clog2_min1(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: address range check, register-0 masking
// and same-cycle write bypass.
module rf_read_port
    import rf_multi_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AW       = clog2_min1(DEF_DEPTH),
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
)(
    input  logic [AW-1:0]    i_rs,
    input  logic [WIDTH-1:0] i_mem_data,
    input  logic [AW-1:0]    i_wn,
    input  logic [WIDTH-1:0] i_wd,
    input  logic             i_wr_legal,
    output logic [WIDTH-1:0] o_rd
);

    localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

    // i_wr_legal already excludes reset, out-of-range and register 0 writes.
    always_comb begin
        o_rd = i_mem_data;
        if ({1'b0, i_rs} >= DEPTH_V) begin
            o_rd = '0;
        end else if ((ZERO_REG != 0) && (i_rs == '0)) begin
            o_rd = '0;
        end else if ((BYPASS != 0) && i_wr_legal && (i_wn == i_rs)) begin
            o_rd = i_wd;
        end
    end

endmodule

// File: rtl/rf_multi.sv
// Parametrised register file: one write port, RPORTS combinational read ports,
// optional hardwired-zero register 0 and optional write-to-read bypass.
module rf_multi
    import rf_multi_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int RPORTS   = DEF_RPORTS,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = clog2_min1(DEPTH)
)(
    input  logic                    clk,
    input  logic                    reset,
    input  logic [RPORTS*AW-1:0]    rs,
    output logic [RPORTS*WIDTH-1:0] rd,
    input  logic [AW-1:0]           wn,
    input  logic [WIDTH-1:0]        wd,
    input  logic                    w
);

    localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [0:DEPTH-1];

    logic w_wn_in_range;
    logic w_wn_zero;
    logic w_wr_legal;

    assign w_wn_in_range = ({1'b0, wn} < DEPTH_V);
    assign w_wn_zero     = (ZERO_REG != 0) && (wn == '0);
    assign w_wr_legal    = w && !reset && w_wn_in_range && !w_wn_zero;

    // Per-entry address compare: an unknown wn never matches, so no entry is disturbed.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (reset) begin
                r_mem[i] <= '0;
            end else if (w_wr_legal && (wn == AW'(i))) begin
                r_mem[i] <= wd;
            end
        end
    end

    for (genvar p = 0; p < RPORTS; p++) begin : g_rport
        logic [AW-1:0]    w_rs;
        logic [WIDTH-1:0] w_mem_data;

        assign w_rs       = rs[p*AW +: AW];
        assign w_mem_data = r_mem[w_rs];

        rf_read_port #(
            .WIDTH    (WIDTH),
            .DEPTH    (DEPTH),
            .AW       (AW),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_rport (
            .i_rs       (w_rs),
            .i_mem_data (w_mem_data),
            .i_wn       (wn),
            .i_wd       (wd),
            .i_wr_legal (w_wr_legal),
            .o_rd       (rd[p*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_rf_multi.sv
// Self-checking bench for rf_multi: default, no-bypass and 3-port/24-deep
// instances share the write side; expected read data is queued then compared.
module tb_rf_multi;

    logic        clk = 1'b0;
    logic        reset;
    logic        w;
    logic [4:0]  wn;
    logic [31:0] wd;
    logic [9:0]  rs_a, rs_b;
    logic [63:0] rd_a, rd_b;
    logic [14:0] rs_c;
    logic [95:0] rd_c;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q [$];
    logic [31:0] model_a [32];
    logic [31:0] model_c [24];

    always #5 clk = ~clk;

    rf_multi dut_a (
        .clk (clk), .reset (reset), .rs (rs_a), .rd (rd_a),
        .wn (wn), .wd (wd), .w (w)
    );

    rf_multi #(.BYPASS(0)) dut_b (
        .clk (clk), .reset (reset), .rs (rs_b), .rd (rd_b),
        .wn (wn), .wd (wd), .w (w)
    );

    rf_multi #(.RPORTS(3), .DEPTH(24)) dut_c (
        .clk (clk), .reset (reset), .rs (rs_c), .rd (rd_c),
        .wn (wn), .wd (wd), .w (w)
    );

    // Advance one clock; the reference model follows the inputs held across the edge.
    task automatic step();
        if (reset) begin
            foreach (model_a[i]) model_a[i] = '0;
            foreach (model_c[i]) model_c[i] = '0;
        end else if (w && wn != 5'd0) begin
            model_a[wn] = wd;
            if (wn < 5'd24) model_c[wn] = wd;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic write_squares();
        for (int i = 0; i < 32; i++) begin
            w = 1'b1; wn = 5'(i); wd = 32'(i * i);
            step();
        end
        w = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] e;
        reset = 1'b1; w = 1'b0; wn = '0; wd = '0;
        rs_a = '0; rs_b = '0; rs_c = '0;
        step();
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rs_a = {2{5'(i)}};
            rs_c = {3{5'(i)}};
            repeat (5) exp_q.push_back(32'd0);
            #2;
            for (int p = 0; p < 2; p++) begin
                e = exp_q.pop_front();
                checks++;
                if (rd_a[p*32 +: 32] !== e) begin
                    errors++;
                    $display("FAIL reset_sweep_a rs=%0d port=%0d got=%h expected=%h", i, p, rd_a[p*32 +: 32], e);
                end
            end
            for (int p = 0; p < 3; p++) begin
                e = exp_q.pop_front();
                checks++;
                if (rd_c[p*32 +: 32] !== e) begin
                    errors++;
                    $display("FAIL reset_sweep_c rs=%0d port=%0d got=%h expected=%h", i, p, rd_c[p*32 +: 32], e);
                end
            end
        end
    endtask

    task automatic test_write_squares();
        logic [31:0] e;
        write_squares();
        rs_a = {5'd5, 5'd0};
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd25);
        #2;
        for (int p = 0; p < 2; p++) begin
            e = exp_q.pop_front();
            checks++;
            if (rd_a[p*32 +: 32] !== e) begin
                errors++;
                $display("FAIL squares_0_5 port=%0d got=%h expected=%h", p, rd_a[p*32 +: 32], e);
            end
        end
        rs_a = {5'd31, 5'd31};
        rs_c = {5'd0, 5'd24, 5'd23};
        exp_q.push_back(32'd961);
        exp_q.push_back(32'd961);
        exp_q.push_back(32'd529);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        #2;
        for (int p = 0; p < 2; p++) begin
            e = exp_q.pop_front();
            checks++;
            if (rd_a[p*32 +: 32] !== e) begin
                errors++;
                $display("FAIL squares_31 port=%0d got=%h expected=%h", p, rd_a[p*32 +: 32], e);
            end
        end
        for (int p = 0; p < 3; p++) begin
            e = exp_q.pop_front();
            checks++;
            if (rd_c[p*32 +: 32] !== e) begin
                errors++;
                $display("FAIL squares_c_edge port=%0d got=%h expected=%h", p, rd_c[p*32 +: 32], e);
            end
        end
    endtask

    task automatic test_hold();
        logic [31:0] e;
        w = 1'b0; wn = 5'd7; wd = 32'hDEAD;
        step();
        rs_a = {5'd7, 5'd7};
        rs_b = {5'd7, 5'd7};
        repeat (4) exp_q.push_back(32'd49);
        #2;
        for (int p = 0; p < 2; p++) begin
            e = exp_q.pop_front();
            checks++;
            if (rd_a[p*32 +: 32] !== e) begin
                errors++;
                $display("FAIL hold_a port=%0d got=%h expected=%h", p, rd_a[p*32 +: 32], e);
            end
        end
        for (int p = 0; p < 2; p++) begin
            e = exp_q.pop_front();
            checks++;
            if (rd_b[p*32 +: 32] !== e) begin
                errors++;
                $display("FAIL hold_b port=%0d got=%h expected=%h", p, rd_b[p*32 +: 32], e);
            end
        end
    endtask

    task automatic test_bypass();
        logic [31:0] e;
        w = 1'b1; wn = 5'd9; wd = 32'h1234;
        rs_a = {5'd8, 5'd9};
        rs_b = {5'd9, 5'd9};
        exp_q.push_back(32'h1234);
        exp_q.push_back(32'd64);
        exp_q.push_back(32'd81);
        exp_q.push_back(32'd81);
        #2;
        for (int p = 0; p < 2; p++) begin
            e = exp_q.pop_front();
            checks++;
            if (rd_a[p*32 +: 32] !== e) begin
                errors++;
                $display("FAIL bypass_a port=%0d got=%h expected=%h", p, rd_a[p*32 +: 32], e);
            end
        end
        for (int p = 0; p < 2; p++) begin
            e = exp_q.pop_front();
            checks++;
            if (rd_b[p*32 +: 32] !== e) begin
                errors++;
                $display("FAIL nobypass_pre port=%0d got=%h expected=%h", p, rd_b[p*32 +: 32], e);
            end
        end
        step();
        w = 1'b0;
        exp_q.push_back(32'h1234);
        exp_q.push_back(32'h1234);
        #2;
        for (int p = 0; p < 2; p++) begin
            e = exp_q.pop_front();
            checks++;
            if (rd_b[p*32 +: 32] !== e) begin
                errors++;
                $display("FAIL nobypass_post port=%0d got=%h expected=%h", p, rd_b[p*32 +: 32], e);
            end
        end
    endtask

    task automatic test_zero_reg();
        logic [31:0] e;
        w = 1'b1; wn = 5'd0; wd = 32'hAAAA_5555;
        rs_a = {5'd0, 5'd0};
        rs_c = {5'd0, 5'd0, 5'd0};
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        #2;
        for (int p = 0; p < 2; p++) begin
            e = exp_q.pop_front();
            checks++;
            if (rd_a[p*32 +: 32] !== e) begin
                errors++;
                $display("FAIL zero_pre port=%0d got=%h expected=%h", p, rd_a[p*32 +: 32], e);
            end
        end
        e = exp_q.pop_front();
        checks++;
        if (rd_c[31:0] !== e) begin
            errors++;
            $display("FAIL zero_pre_c got=%h expected=%h", rd_c[31:0], e);
        end
        step();
        w = 1'b0;
        exp_q.push_back(model_a[0]);
        #2;
        e = exp_q.pop_front();
        checks++;
        if (rd_a[31:0] !== e) begin
            errors++;
            $display("FAIL zero_post got=%h expected=%h", rd_a[31:0], e);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e;
        rs_a = {5'd11, 5'd12};
        for (int k = 0; k < 3; k++) begin
            w = 1'b1; wn = 5'd12; wd = 32'hA000_0000 + 32'(k);
            exp_q.push_back(wd);
            exp_q.push_back(model_a[11]);
            #2;
            for (int p = 0; p < 2; p++) begin
                e = exp_q.pop_front();
                checks++;
                if (rd_a[p*32 +: 32] !== e) begin
                    errors++;
                    $display("FAIL b2b k=%0d port=%0d got=%h expected=%h", k, p, rd_a[p*32 +: 32], e);
                end
            end
            step();
        end
        w = 1'b0;
        rs_b = {5'd12, 5'd12};
        exp_q.push_back(32'hA000_0002);
        #2;
        e = exp_q.pop_front();
        checks++;
        if (rd_b[63:32] !== e) begin
            errors++;
            $display("FAIL b2b_final got=%h expected=%h", rd_b[63:32], e);
        end
    endtask

    task automatic test_reset_write();
        logic [31:0] e;
        reset = 1'b1; w = 1'b1; wn = 5'd3; wd = 32'd5;
        rs_a = {5'd3, 5'd3};
        exp_q.push_back(32'd9);
        exp_q.push_back(32'd9);
        #2;
        for (int p = 0; p < 2; p++) begin
            e = exp_q.pop_front();
            checks++;
            if (rd_a[p*32 +: 32] !== e) begin
                errors++;
                $display("FAIL reset_nobypass port=%0d got=%h expected=%h", p, rd_a[p*32 +: 32], e);
            end
        end
        step();
        reset = 1'b0; w = 1'b0;
        rs_c = {5'd3, 5'd3, 5'd3};
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        #2;
        for (int p = 0; p < 2; p++) begin
            e = exp_q.pop_front();
            checks++;
            if (rd_a[p*32 +: 32] !== e) begin
                errors++;
                $display("FAIL reset_write_a port=%0d got=%h expected=%h", p, rd_a[p*32 +: 32], e);
            end
        end
        e = exp_q.pop_front();
        checks++;
        if (rd_c[31:0] !== e) begin
            errors++;
            $display("FAIL reset_write_c got=%h expected=%h", rd_c[31:0], e);
        end
    endtask

    task automatic test_multi_port();
        logic [31:0] e;
        write_squares();
        w = 1'b1; wn = 5'd30; wd = 32'hFFFF_FFFF;
        step();
        w = 1'b0;
        rs_c = {5'd4, 5'd4, 5'd4};
        rs_a = {5'd30, 5'd30};
        repeat (3) exp_q.push_back(32'd16);
        exp_q.push_back(32'hFFFF_FFFF);
        #2;
        for (int p = 0; p < 3; p++) begin
            e = exp_q.pop_front();
            checks++;
            if (rd_c[p*32 +: 32] !== e) begin
                errors++;
                $display("FAIL multi_rs4 port=%0d got=%h expected=%h", p, rd_c[p*32 +: 32], e);
            end
        end
        e = exp_q.pop_front();
        checks++;
        if (rd_a[31:0] !== e) begin
            errors++;
            $display("FAIL multi_a_rs30 got=%h expected=%h", rd_a[31:0], e);
        end
        rs_c = {5'd4, 5'd31, 5'd30};
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd16);
        #2;
        for (int p = 0; p < 3; p++) begin
            e = exp_q.pop_front();
            checks++;
            if (rd_c[p*32 +: 32] !== e) begin
                errors++;
                $display("FAIL multi_oob port=%0d got=%h expected=%h", p, rd_c[p*32 +: 32], e);
            end
        end
        for (int i = 0; i < 24; i++) begin
            rs_c = {5'd0, 5'd0, 5'(i)};
            exp_q.push_back(model_c[i]);
            #2;
            e = exp_q.pop_front();
            checks++;
            if (rd_c[31:0] !== e) begin
                errors++;
                $display("FAIL multi_sweep rs=%0d got=%h expected=%h", i, rd_c[31:0], e);
            end
        end
    endtask

    initial begin
        reset = 1'b0; w = 1'b0; wn = '0; wd = '0;
        rs_a = '0; rs_b = '0; rs_c = '0;
        @(negedge clk);
        test_reset();
        test_write_squares();
        test_hold();
        test_bypass();
        test_zero_reg();
        test_back_to_back();
        test_reset_write();
        test_multi_port();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
